// File: rtl/usb_tx_framer.sv
// Packet framer feeding SYNC/PID/payload byte slots to a parallel-in serializer with a payload prefetch FIFO.
// Optional macro USB_TX_FRAMER_SYNC_EN: when defined the SYNC slot is emitted here, otherwise framing starts at PID.
module usb_tx_framer #(
    parameter int MAX_LEN     = 64,
    parameter int BYTE_CYCLES = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic [6:0] len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] tx_byte,
    output logic       load,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);
    localparam int CNT_W  = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(BYTE_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN_V  = 8'(MAX_LEN);
    localparam logic [OCC_W-1:0] FIFO_FULLV = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_GAP
    } state_t;

`ifdef USB_TX_FRAMER_SYNC_EN
    localparam state_t FIRST_STATE = ST_SYNC;
`else
    localparam state_t FIRST_STATE = ST_PID;
`endif

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   slot_cnt;
    logic [CNT_W-1:0]   slot_nx;
    logic               slot_end;
    logic               slot_start;

    logic [3:0]         pid_q;
    logic [6:0]         len_q;
    logic [6:0]         acc_cnt;
    logic [6:0]         sent_cnt;
    logic               done_q;
    logic               err_q;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic [7:0]         data_q;

    logic               accept;
    logic               enter_data;
    logic               underrun;
    logic               finish;
    logic               pop;
    logic               wr_fire;

    assign slot_end   = (slot_cnt == SLOT_LAST);
    assign slot_start = (slot_cnt == '0);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULLV);

    assign busy         = (state != ST_IDLE);
    assign wr_ready     = busy && !fifo_full && (acc_cnt < len_q);
    assign wr_fire      = wr_valid && wr_ready;
    assign pop          = enter_data && !fifo_empty;
    assign done         = done_q;
    assign err_underrun = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
        end else begin
            state    <= state_nx;
            slot_cnt <= slot_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        slot_nx    = slot_cnt;
        accept     = 1'b0;
        enter_data = 1'b0;
        underrun   = 1'b0;
        finish     = 1'b0;
        if (state == ST_IDLE) begin
            slot_nx = '0;
            if (start && ({1'b0, len} <= MAX_LEN_V)) begin
                accept   = 1'b1;
                state_nx = FIRST_STATE;
            end
        end else begin
            slot_nx = slot_end ? '0 : slot_cnt + CNT_W'(1);
            if (slot_end) begin
                case (state)
                    ST_SYNC: state_nx = ST_PID;
                    ST_PID: begin
                        if (len_q != '0) enter_data = 1'b1;
                        else             state_nx   = ST_GAP;
                    end
                    ST_DATA: begin
                        if (sent_cnt < len_q) enter_data = 1'b1;
                        else                  state_nx   = ST_GAP;
                    end
                    ST_GAP: begin
                        state_nx = ST_IDLE;
                        finish   = 1'b1;
                    end
                    default: state_nx = ST_IDLE;
                endcase
            end
        end
        // Occupancy is the registered count: a write landing on this edge cannot rescue an empty FIFO.
        if (enter_data) begin
            if (fifo_empty) begin
                underrun = 1'b1;
                state_nx = ST_IDLE;
                slot_nx  = '0;
            end else begin
                state_nx = ST_DATA;
            end
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        load    = 1'b0;
        case (state)
            ST_SYNC: begin
                tx_byte = 8'h80;
                load    = slot_start;
            end
            ST_PID: begin
                tx_byte = {~pid_q, pid_q};
                load    = slot_start;
            end
            ST_DATA: begin
                tx_byte = data_q;
                load    = slot_start;
            end
            default: begin
                tx_byte = 8'h00;
                load    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt  <= '0;
            sent_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                acc_cnt  <= '0;
                sent_cnt <= '0;
                err_q    <= 1'b0;
            end else begin
                if (wr_fire)  acc_cnt  <= acc_cnt + 7'd1;
                if (pop)      sent_cnt <= sent_cnt + 7'd1;
                if (underrun) err_q    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pid_q <= pid;
            len_q <= len;
        end
    end

    // Flush wins over a same-edge write so an aborted packet leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst || underrun) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, pop})
                2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
        if (pop)     data_q      <= mem[rd_ptr];
    end

endmodule
